mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter and sequencer between the IF stage (instruction fetch) and the MEM stage (load/store). It owns the one `sram` controller port (`en`/`op`/`addr`/`data_i`/`data_o`) and the UART strobes (`rdn`/`wrn`). It serialises accesses with fixed MEM-over-IF priority and runs the multi-cycle SRAM and UART strobe sequences. It returns per-requester ack pulses, and raises stall levels that the pipeline uses for `PC_pause` and the IF/ID pause.

## Interface
Parameters:
- `SRAM_CYCLES`, default 2: cycles `sram_en` is held per SRAM access (legal range 1..7).
- `UART_CYCLES`, default 2: cycles `rdn`/`wrn` is held low per UART access (legal range 1..7).
- `UART_DATA_ADDR`, default 16'hBF00: logical address of the UART data register.
- `UART_STAT_ADDR`, default 16'hBF01: logical address of the UART status register.

Ports:
- `clk`, input, 1: the only clock. Everything is registered on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `if_req`, input, 1: fetch request level, held until `if_ack`.
- `if_addr`, input, 16: fetch address.
- `if_rdata`, output, 16: fetched instruction, valid with `if_ack` and held until the next `if_ack`.
- `if_ack`, output, 1: one-cycle completion pulse for the fetch.
- `mem_req`, input, 1: data request level, held until `mem_ack`.
- `mem_we`, input, 1: 1 = store, 0 = load.
- `mem_addr`, input, 16: data address.
- `mem_wdata`, input, 16: store data.
- `mem_rdata`, output, 16: load data, valid with `mem_ack` and held until the next `mem_ack`.
- `mem_ack`, output, 1: one-cycle completion pulse for the data access.
- `stall_if`, output, 1: combinational, equals `if_req & ~if_ack`.
- `stall_mem`, output, 1: combinational, equals `mem_req & ~mem_ack`.
- `sram_en`, output, 1: enable to the `sram` controller.
- `sram_op`, output, 1: 0 = read, 1 = write.
- `sram_addr`, output, 18: zero-extended as {2'b00, addr}.
- `sram_wdata`, output, 16: write data to the `sram` controller.
- `sram_rdata`, input, 16: read data from the `sram` controller.
- `tsre`, input, 1: UART status.
- `tbre`, input, 1: UART status.
- `data_ready`, input, 1: UART status.
- `uart_rdata`, input, 16: UART data bus in (bits [7:0] valid).
- `uart_wdata`, output, 16: UART data bus out.
- `uart_oe`, output, 1: 1 while `uart_wdata` is driven.
- `rdn`, output, 1: active-low UART read strobe.
- `wrn`, output, 1: active-low UART write strobe.

## Operation
- States: IDLE, SRAM, UART_RD, UART_WR. A 3-bit down-counter `cnt` times the SRAM, UART_RD and UART_WR states.
- Grant is decided only in IDLE.
  - An eligible `mem_req` wins over an eligible `if_req`.
  - A requester is ineligible in the cycle its own ack is high, because its `req` still reflects the completed access.
- Decode of a granted request:
  - A MEM request with `mem_addr == UART_DATA_ADDR` goes to UART_RD if `mem_we`=0, or to UART_WR if `mem_we`=1.
  - A load with `mem_addr == UART_STAT_ADDR` completes without leaving IDLE. `mem_rdata` = {14'b0, `data_ready`, `tsre & tbre`}, and `mem_ack` is pulsed the next cycle.
  - A store to `UART_STAT_ADDR` is acked the next cycle with no side effect.
  - Every other access, including all IF accesses, goes to SRAM.
- SRAM state:
  - Registered outputs are `sram_en`=1, with `sram_op`, `sram_addr` and `sram_wdata` latched at grant and stable for the whole state.
  - On the last cycle (`cnt`==1), `sram_rdata` is captured into the granted requester's rdata register, the ack is registered, the FSM returns to IDLE and `sram_en` drops.
- UART_RD: `rdn`=0 for `UART_CYCLES` cycles. `uart_rdata` is captured as {8'b0, `uart_rdata[7:0]`} on the last cycle, then `rdn`=1 and `mem_ack`.
- UART_WR: `uart_oe`=1 and `uart_wdata`=`mem_wdata` for the whole state, with `wrn`=0 for `UART_CYCLES` cycles. Then `wrn`=1, `uart_oe`=0 and `mem_ack`. The block does not check `tbre`/`tsre`; software polls status first.
- Requests in SRAM/UART states are not sampled. Address and data are used only as latched at grant.

## Timing
- Reset values (one edge after `rst`=1):
  - State IDLE, `cnt`=0.
  - `sram_en`=0, `sram_op`=0, `sram_addr`=0, `sram_wdata`=0.
  - `rdn`=1, `wrn`=1, `uart_oe`=0, `uart_wdata`=0.
  - `if_ack`=0, `mem_ack`=0, `if_rdata`=0, `mem_rdata`=0.
- Reset mid-access aborts immediately. No ack is issued, strobes return inactive on that edge, and the pending access is dropped. The requester re-presents it.
- SRAM access latency: grant in cycle 0 (IDLE), `sram_en` high in cycles 1..`SRAM_CYCLES`, ack high in cycle `SRAM_CYCLES`+1. That cycle is IDLE and may grant the other requester. Back-to-back accesses from one requester therefore take `SRAM_CYCLES`+2 cycles each.
- UART latency follows the same pattern with `UART_CYCLES`. A status access acks in cycle 1.
- Both `req` signals high in IDLE with neither acked: MEM is granted, and IF waits with `stall_if`=1.
- `if_ack` and `mem_ack` are never high in the same cycle.

## Test plan
- Reset, then `if_req`=1, `if_addr`=16'h0004, `sram_rdata`=16'h6801 -> `sram_en` high in cycles 1-2 with `sram_addr`=18'h00004 and `sram_op`=0; `if_ack` high in cycle 3 with `if_rdata`=16'h6801; `stall_if` low in cycle 3.
- `if_req` and `mem_req` (store, 16'h4000 <- 16'hBEEF) rise together -> SRAM write first (`sram_op`=1, `sram_wdata`=16'hBEEF), `mem_ack` in cycle 3, then fetch granted in cycle 3, `if_ack` in cycle 6.
- Load from 16'hBF01 with `data_ready`=1, `tsre`=1, `tbre`=0 -> `mem_ack` in cycle 1, `mem_rdata`=16'h0002, no strobe toggles.
- Store 16'h0041 to 16'hBF00 -> `wrn` low in cycles 1-2 with `uart_oe`=1 and `uart_wdata`=16'h0041; `mem_ack` in cycle 3; `rdn` stays 1.
- Load from 16'hBF00 with `uart_rdata`=16'hFF5A -> `rdn` low in cycles 1-2, `mem_rdata`=16'h005A with `mem_ack` in cycle 3.
- `rst` asserted in cycle 1 of an SRAM read -> cycle 2: `sram_en`=0, no ack ever; after release, the held `if_req` is regranted and completes normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the arbiter's pipeline, SRAM-controller and UART signals.
// The slave modport is the arbiter's view; the master modport is its surroundings.
interface mem_arbiter_if;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_ack;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        stall_if;
    logic        stall_mem;
    logic        sram_en;
    logic        sram_op;
    logic [17:0] sram_addr;
    logic [15:0] sram_wdata;
    logic [15:0] sram_rdata;
    logic        tsre;
    logic        tbre;
    logic        data_ready;
    logic [15:0] uart_rdata;
    logic [15:0] uart_wdata;
    logic        uart_oe;
    logic        rdn;
    logic        wrn;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
        input  sram_rdata, tsre, tbre, data_ready, uart_rdata,
        output if_rdata, if_ack, mem_rdata, mem_ack, stall_if, stall_mem,
        output sram_en, sram_op, sram_addr, sram_wdata,
        output uart_wdata, uart_oe, rdn, wrn
    );

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
        output sram_rdata, tsre, tbre, data_ready, uart_rdata,
        input  if_rdata, if_ack, mem_rdata, mem_ack, stall_if, stall_mem,
        input  sram_en, sram_op, sram_addr, sram_wdata,
        input  uart_wdata, uart_oe, rdn, wrn
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: MEM-over-IF priority onto one SRAM port plus
// UART data/status registers, with timed strobe sequences and ack pulses.
module mem_arbiter #(
    parameter int          SRAM_CYCLES    = 2,
    parameter int          UART_CYCLES    = 2,
    parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
    parameter logic [15:0] UART_STAT_ADDR = 16'hBF01
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SRAM, UART_RD, UART_WR} state_t;

    localparam logic [2:0] SRAM_CNT = 3'(SRAM_CYCLES);
    localparam logic [2:0] UART_CNT = 3'(UART_CYCLES);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        owner_mem_q, owner_mem_d;
    logic        sram_en_q, sram_en_d;
    logic        sram_op_q, sram_op_d;
    logic [17:0] sram_addr_q, sram_addr_d;
    logic [15:0] sram_wdata_q, sram_wdata_d;
    logic        rdn_q, rdn_d;
    logic        wrn_q, wrn_d;
    logic        uart_oe_q, uart_oe_d;
    logic [15:0] uart_wdata_q, uart_wdata_d;
    logic        if_ack_q, if_ack_d;
    logic        mem_ack_q, mem_ack_d;
    logic [15:0] if_rdata_q, if_rdata_d;
    logic [15:0] mem_rdata_q, mem_rdata_d;

    // A requester whose ack is high this cycle still shows the finished request.
    logic if_elig, mem_elig;
    assign if_elig  = bus.if_req  & ~if_ack_q;
    assign mem_elig = bus.mem_req & ~mem_ack_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_mem_d  = owner_mem_q;
        sram_en_d    = sram_en_q;
        sram_op_d    = sram_op_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        rdn_d        = rdn_q;
        wrn_d        = wrn_q;
        uart_oe_d    = uart_oe_q;
        uart_wdata_d = uart_wdata_q;
        if_ack_d     = 1'b0;
        mem_ack_d    = 1'b0;
        if_rdata_d   = if_rdata_q;
        mem_rdata_d  = mem_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (mem_elig) begin
                    owner_mem_d = 1'b1;
                    if (bus.mem_addr == UART_DATA_ADDR) begin
                        cnt_d = UART_CNT;
                        if (bus.mem_we) begin
                            state_d      = UART_WR;
                            wrn_d        = 1'b0;
                            uart_oe_d    = 1'b1;
                            uart_wdata_d = bus.mem_wdata;
                        end else begin
                            state_d = UART_RD;
                            rdn_d   = 1'b0;
                        end
                    end else if (bus.mem_addr == UART_STAT_ADDR) begin
                        // Status completes from IDLE; stores to it are silently acked.
                        mem_ack_d = 1'b1;
                        if (!bus.mem_we)
                            mem_rdata_d = {14'b0, bus.data_ready, bus.tsre & bus.tbre};
                    end else begin
                        state_d      = SRAM;
                        cnt_d        = SRAM_CNT;
                        sram_en_d    = 1'b1;
                        sram_op_d    = bus.mem_we;
                        sram_addr_d  = {2'b00, bus.mem_addr};
                        sram_wdata_d = bus.mem_wdata;
                    end
                end else if (if_elig) begin
                    owner_mem_d = 1'b0;
                    state_d     = SRAM;
                    cnt_d       = SRAM_CNT;
                    sram_en_d   = 1'b1;
                    sram_op_d   = 1'b0;
                    sram_addr_d = {2'b00, bus.if_addr};
                end
            end
            SRAM: begin
                if (cnt_q == 3'd1) begin
                    state_d   = IDLE;
                    cnt_d     = 3'd0;
                    sram_en_d = 1'b0;
                    if (owner_mem_q) begin
                        mem_ack_d = 1'b1;
                        if (!sram_op_q)
                            mem_rdata_d = bus.sram_rdata;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus.sram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            UART_RD: begin
                if (cnt_q == 3'd1) begin
                    state_d     = IDLE;
                    cnt_d       = 3'd0;
                    rdn_d       = 1'b1;
                    mem_ack_d   = 1'b1;
                    mem_rdata_d = {8'b0, bus.uart_rdata[7:0]};
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            UART_WR: begin
                if (cnt_q == 3'd1) begin
                    state_d   = IDLE;
                    cnt_d     = 3'd0;
                    wrn_d     = 1'b1;
                    uart_oe_d = 1'b0;
                    mem_ack_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            owner_mem_q  <= 1'b0;
            sram_en_q    <= 1'b0;
            sram_op_q    <= 1'b0;
            sram_addr_q  <= 18'd0;
            sram_wdata_q <= 16'd0;
            rdn_q        <= 1'b1;
            wrn_q        <= 1'b1;
            uart_oe_q    <= 1'b0;
            uart_wdata_q <= 16'd0;
            if_ack_q     <= 1'b0;
            mem_ack_q    <= 1'b0;
            if_rdata_q   <= 16'd0;
            mem_rdata_q  <= 16'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_mem_q  <= owner_mem_d;
            sram_en_q    <= sram_en_d;
            sram_op_q    <= sram_op_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            rdn_q        <= rdn_d;
            wrn_q        <= wrn_d;
            uart_oe_q    <= uart_oe_d;
            uart_wdata_q <= uart_wdata_d;
            if_ack_q     <= if_ack_d;
            mem_ack_q    <= mem_ack_d;
            if_rdata_q   <= if_rdata_d;
            mem_rdata_q  <= mem_rdata_d;
        end
    end

    assign bus.if_rdata   = if_rdata_q;
    assign bus.if_ack     = if_ack_q;
    assign bus.mem_rdata  = mem_rdata_q;
    assign bus.mem_ack    = mem_ack_q;
    assign bus.stall_if   = bus.if_req & ~if_ack_q;
    assign bus.stall_mem  = bus.mem_req & ~mem_ack_q;
    assign bus.sram_en    = sram_en_q;
    assign bus.sram_op    = sram_op_q;
    assign bus.sram_addr  = sram_addr_q;
    assign bus.sram_wdata = sram_wdata_q;
    assign bus.uart_wdata = uart_wdata_q;
    assign bus.uart_oe    = uart_oe_q;
    assign bus.rdn        = rdn_q;
    assign bus.wrn        = wrn_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter: expected acks are queued at stimulus time
// and matched (requester, data, cycle) when the DUT pulses an ack.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(
        .SRAM_CYCLES(2), .UART_CYCLES(2),
        .UART_DATA_ADDR(16'hBF00), .UART_STAT_ADDR(16'hBF01)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        is_mem;
        logic        chk_data;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Ack monitor: pops the scoreboard on every ack pulse.
    always @(negedge clk) begin
        if (!rst && (bus.if_ack === 1'b1 || bus.mem_ack === 1'b1)) begin
            logic        got_mem;
            logic [15:0] got_data;
            exp_t        e;
            got_mem  = (bus.mem_ack === 1'b1);
            got_data = got_mem ? bus.mem_rdata : bus.if_rdata;
            $display("ack %s data=%h cycle=%0d", got_mem ? "mem" : "if", got_data, cyc);
            checks++;
            if (bus.if_ack === 1'b1 && bus.mem_ack === 1'b1) begin
                errors++;
                $display("FAIL both_acks got=11 exp=one-hot cycle=%0d", cyc);
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack got_mem=%b cycle=%0d exp=none", got_mem, cyc);
            end else begin
                e = sb.pop_front();
                if (got_mem !== e.is_mem || cyc != e.cyc || (e.chk_data && got_data !== e.data)) begin
                    errors++;
                    $display("FAIL ack_match got mem=%b data=%h cyc=%0d exp mem=%b data=%h cyc=%0d",
                             got_mem, got_data, cyc, e.is_mem, e.data, e.cyc);
                end
            end
        end
    end

    task automatic push(input logic is_mem, input logic chk, input logic [15:0] d, input int c);
        exp_t e;
        e.is_mem = is_mem; e.chk_data = chk; e.data = d; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic idle_inputs();
        bus.if_req = 0; bus.if_addr = 0; bus.mem_req = 0; bus.mem_we = 0;
        bus.mem_addr = 0; bus.mem_wdata = 0; bus.sram_rdata = 0;
        bus.tsre = 0; bus.tbre = 0; bus.data_ready = 0; bus.uart_rdata = 0;
    endtask

    task automatic drain(input string name);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_ack got=%0d pending exp=0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.sram_en, bus.sram_op, bus.sram_addr, bus.sram_wdata} !== 36'd0) begin
            errors++;
            $display("FAIL reset_sram got=%b/%b/%h/%h exp=0", bus.sram_en, bus.sram_op, bus.sram_addr, bus.sram_wdata);
        end
        checks++;
        if ({bus.rdn, bus.wrn, bus.uart_oe, bus.uart_wdata} !== {1'b1, 1'b1, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL reset_uart got=%b%b%b/%h exp=110/0000", bus.rdn, bus.wrn, bus.uart_oe, bus.uart_wdata);
        end
        checks++;
        if ({bus.if_ack, bus.mem_ack, bus.if_rdata, bus.mem_rdata} !== 34'd0) begin
            errors++;
            $display("FAIL reset_ack got=%b%b/%h/%h exp=0", bus.if_ack, bus.mem_ack, bus.if_rdata, bus.mem_rdata);
        end
        rst = 0;
    endtask

    task automatic test_if_fetch();
        int t0;
        @(posedge clk); #1;
        bus.if_req = 1; bus.if_addr = 16'h0004; bus.sram_rdata = 16'h6801;
        t0 = cyc;
        push(0, 1, 16'h6801, t0 + 3);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (bus.sram_en !== (k == 1 || k == 2)) begin
                errors++;
                $display("FAIL fetch_sram_en k=%0d got=%b", k, bus.sram_en);
            end
            if (k == 1 || k == 2) begin
                checks++;
                if (bus.sram_addr !== 18'h00004 || bus.sram_op !== 1'b0) begin
                    errors++;
                    $display("FAIL fetch_addr k=%0d got=%h/%b exp=00004/0", k, bus.sram_addr, bus.sram_op);
                end
            end
            if (k <= 3) begin
                checks++;
                if (bus.stall_if !== (k != 3)) begin
                    errors++;
                    $display("FAIL fetch_stall_if k=%0d got=%b exp=%b", k, bus.stall_if, k != 3);
                end
            end
            if (bus.if_ack === 1'b1) bus.if_req = 0;
        end
        drain("fetch");
    endtask

    task automatic test_priority();
        int t0;
        @(posedge clk); #1;
        bus.if_req = 1; bus.if_addr = 16'h0010; bus.sram_rdata = 16'h1234;
        bus.mem_req = 1; bus.mem_we = 1; bus.mem_addr = 16'h4000; bus.mem_wdata = 16'hBEEF;
        t0 = cyc;
        push(1, 0, 16'h0000, t0 + 3);
        push(0, 1, 16'h1234, t0 + 6);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (bus.sram_en !== (k == 1 || k == 2 || k == 4 || k == 5)) begin
                errors++;
                $display("FAIL prio_sram_en k=%0d got=%b", k, bus.sram_en);
            end
            if (k == 1 || k == 2) begin
                checks++;
                if (bus.sram_op !== 1'b1 || bus.sram_addr !== 18'h04000 || bus.sram_wdata !== 16'hBEEF) begin
                    errors++;
                    $display("FAIL prio_store k=%0d got=%b/%h/%h exp=1/04000/beef", k, bus.sram_op, bus.sram_addr, bus.sram_wdata);
                end
            end
            if (k == 4 || k == 5) begin
                checks++;
                if (bus.sram_op !== 1'b0 || bus.sram_addr !== 18'h00010) begin
                    errors++;
                    $display("FAIL prio_fetch k=%0d got=%b/%h exp=0/00010", k, bus.sram_op, bus.sram_addr);
                end
            end
            if (k < 6) begin
                checks++;
                if (bus.stall_if !== 1'b1) begin
                    errors++;
                    $display("FAIL prio_stall_if k=%0d got=%b exp=1", k, bus.stall_if);
                end
            end
            if (bus.mem_ack === 1'b1) bus.mem_req = 0;
            if (bus.if_ack === 1'b1) bus.if_req = 0;
        end
        drain("prio");
    endtask

    task automatic test_back_to_back();
        int t0;
        @(posedge clk); #1;
        bus.if_req = 1; bus.if_addr = 16'h0100; bus.sram_rdata = 16'h1111;
        t0 = cyc;
        push(0, 1, 16'h1111, t0 + 3);
        push(0, 1, 16'h2222, t0 + 7);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            checks++;
            if (bus.sram_en !== (k == 1 || k == 2 || k == 5 || k == 6)) begin
                errors++;
                $display("FAIL b2b_sram_en k=%0d got=%b", k, bus.sram_en);
            end
            if (k == 3) begin
                bus.if_addr = 16'h0101; bus.sram_rdata = 16'h2222;
            end else if (bus.if_ack === 1'b1) begin
                bus.if_req = 0;
            end
        end
        drain("b2b");
    endtask

    task automatic test_status();
        int t0;
        @(posedge clk); #1;
        bus.mem_req = 1; bus.mem_we = 0; bus.mem_addr = 16'hBF01;
        bus.data_ready = 1; bus.tsre = 1; bus.tbre = 0;
        t0 = cyc;
        push(1, 1, 16'h0002, t0 + 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (bus.rdn !== 1'b1 || bus.wrn !== 1'b1 || bus.sram_en !== 1'b0 || bus.uart_oe !== 1'b0) begin
                errors++;
                $display("FAIL status_strobes k=%0d got rdn=%b wrn=%b en=%b oe=%b exp=1100", k, bus.rdn, bus.wrn, bus.sram_en, bus.uart_oe);
            end
            if (bus.mem_ack === 1'b1) bus.mem_req = 0;
        end
        drain("status_rd");
        @(posedge clk); #1;
        bus.mem_req = 1; bus.mem_we = 1; bus.mem_wdata = 16'h00FF;
        t0 = cyc;
        push(1, 0, 16'h0000, t0 + 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (bus.wrn !== 1'b1 || bus.sram_en !== 1'b0) begin
                errors++;
                $display("FAIL status_wr_strobes k=%0d got wrn=%b en=%b exp=1/0", k, bus.wrn, bus.sram_en);
            end
            if (bus.mem_ack === 1'b1) bus.mem_req = 0;
        end
        drain("status_wr");
    endtask

    task automatic test_uart_wr();
        int t0;
        @(posedge clk); #1;
        bus.mem_req = 1; bus.mem_we = 1; bus.mem_addr = 16'hBF00; bus.mem_wdata = 16'h0041;
        t0 = cyc;
        push(1, 0, 16'h0000, t0 + 3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (bus.wrn !== !(k == 1 || k == 2) || bus.uart_oe !== (k == 1 || k == 2) || bus.rdn !== 1'b1) begin
                errors++;
                $display("FAIL uart_wr_strobes k=%0d got wrn=%b oe=%b rdn=%b", k, bus.wrn, bus.uart_oe, bus.rdn);
            end
            if (k == 1 || k == 2) begin
                checks++;
                if (bus.uart_wdata !== 16'h0041 || bus.sram_en !== 1'b0) begin
                    errors++;
                    $display("FAIL uart_wr_data k=%0d got=%h en=%b exp=0041/0", k, bus.uart_wdata, bus.sram_en);
                end
            end
            if (bus.mem_ack === 1'b1) bus.mem_req = 0;
        end
        drain("uart_wr");
    endtask

    task automatic test_uart_rd();
        int t0;
        @(posedge clk); #1;
        bus.mem_req = 1; bus.mem_we = 0; bus.mem_addr = 16'hBF00; bus.uart_rdata = 16'hFF5A;
        t0 = cyc;
        push(1, 1, 16'h005A, t0 + 3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (bus.rdn !== !(k == 1 || k == 2) || bus.wrn !== 1'b1 || bus.uart_oe !== 1'b0) begin
                errors++;
                $display("FAIL uart_rd_strobes k=%0d got rdn=%b wrn=%b oe=%b", k, bus.rdn, bus.wrn, bus.uart_oe);
            end
            if (k <= 3) begin
                checks++;
                if (bus.stall_mem !== (k != 3)) begin
                    errors++;
                    $display("FAIL uart_rd_stall_mem k=%0d got=%b exp=%b", k, bus.stall_mem, k != 3);
                end
            end
            if (bus.mem_ack === 1'b1) bus.mem_req = 0;
        end
        drain("uart_rd");
    endtask

    task automatic test_reset_abort();
        int t0;
        @(posedge clk); #1;
        bus.if_req = 1; bus.if_addr = 16'h0020; bus.sram_rdata = 16'hAAAA;
        t0 = cyc;
        push(0, 1, 16'h5151, t0 + 5);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (bus.sram_en !== 1'b1) begin
                    errors++;
                    $display("FAIL abort_pre_en got=%b exp=1", bus.sram_en);
                end
                rst = 1;
            end else if (k == 2) begin
                checks++;
                if (bus.sram_en !== 1'b0 || bus.if_ack !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_cut got en=%b ack=%b exp=0/0", bus.sram_en, bus.if_ack);
                end
                rst = 0;
                bus.sram_rdata = 16'h5151;
            end else if (k == 3 || k == 4) begin
                checks++;
                if (bus.sram_en !== 1'b1 || bus.sram_addr !== 18'h00020) begin
                    errors++;
                    $display("FAIL abort_regrant k=%0d got en=%b addr=%h exp=1/00020", k, bus.sram_en, bus.sram_addr);
                end
            end
            if (bus.if_ack === 1'b1) bus.if_req = 0;
        end
        drain("abort");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_if_fetch();
        test_priority();
        test_back_to_back();
        test_status();
        test_uart_wr();
        test_uart_rd();
        test_reset_abort();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
